// File: rtl/key_entry_pkg.sv
// Shared types and PS/2 scan-code constants for the key_entry keyboard front-end.
package key_entry_pkg;

   typedef enum logic [1:0] {
      ST_ENTER_A = 2'd0,
      ST_ENTER_B = 2'd1,
      ST_SHOW    = 2'd2
   } entry_state_e;

   typedef enum logic [2:0] {
      KEY_NONE  = 3'd0,
      KEY_DIGIT = 3'd1,
      KEY_ENTER = 3'd2,
      KEY_BKSP  = 3'd3,
      KEY_ESC   = 3'd4
   } key_class_e;

   // Codes are {E0 flag, 8-bit make code}.
   localparam logic [8:0] SC_TOP_0 = 9'h045;
   localparam logic [8:0] SC_TOP_1 = 9'h016;
   localparam logic [8:0] SC_TOP_2 = 9'h01E;
   localparam logic [8:0] SC_TOP_3 = 9'h026;
   localparam logic [8:0] SC_TOP_4 = 9'h025;
   localparam logic [8:0] SC_TOP_5 = 9'h02E;
   localparam logic [8:0] SC_TOP_6 = 9'h036;
   localparam logic [8:0] SC_TOP_7 = 9'h03D;
   localparam logic [8:0] SC_TOP_8 = 9'h03E;
   localparam logic [8:0] SC_TOP_9 = 9'h046;

   localparam logic [8:0] SC_ENTER = 9'h05A;
   localparam logic [8:0] SC_BKSP  = 9'h066;
   localparam logic [8:0] SC_ESC   = 9'h076;

   localparam logic [8:0] SC_PAD_0     = 9'h070;
   localparam logic [8:0] SC_PAD_1     = 9'h069;
   localparam logic [8:0] SC_PAD_2     = 9'h072;
   localparam logic [8:0] SC_PAD_3     = 9'h07A;
   localparam logic [8:0] SC_PAD_4     = 9'h06B;
   localparam logic [8:0] SC_PAD_5     = 9'h073;
   localparam logic [8:0] SC_PAD_6     = 9'h074;
   localparam logic [8:0] SC_PAD_7     = 9'h06C;
   localparam logic [8:0] SC_PAD_8     = 9'h075;
   localparam logic [8:0] SC_PAD_9     = 9'h07D;
   localparam logic [8:0] SC_PAD_ENTER = 9'h15A;

endpackage

// File: rtl/key_entry_if.sv
// Keyboard decoder event bus: one key_valid pulse per make/break event.
interface key_entry_if #(
   parameter int SCAN_W = 9
);
   logic              key_valid;
   logic [SCAN_W-1:0] last_change;
   logic              key_make;

   modport master (output key_valid, output last_change, output key_make);
   modport slave  (input  key_valid, input  last_change, input  key_make);
endinterface

// File: rtl/key_entry_scan_to_bcd.sv
// Combinational scan-code classifier: code -> {key class, BCD digit}.
// Keypad digits and keypad Enter are recognised only when KEY_ENTRY_NUMPAD_EN is defined.
module scan_to_bcd
   import key_entry_pkg::*;
#(
   parameter int SCAN_W = 9
) (
   input  logic [SCAN_W-1:0] code,
   output key_class_e        key_class,
   output logic [3:0]        digit
);

   always_comb begin
      key_class = KEY_DIGIT;
      digit     = 4'd0;
      case (code)
         SCAN_W'(SC_TOP_0): digit = 4'd0;
         SCAN_W'(SC_TOP_1): digit = 4'd1;
         SCAN_W'(SC_TOP_2): digit = 4'd2;
         SCAN_W'(SC_TOP_3): digit = 4'd3;
         SCAN_W'(SC_TOP_4): digit = 4'd4;
         SCAN_W'(SC_TOP_5): digit = 4'd5;
         SCAN_W'(SC_TOP_6): digit = 4'd6;
         SCAN_W'(SC_TOP_7): digit = 4'd7;
         SCAN_W'(SC_TOP_8): digit = 4'd8;
         SCAN_W'(SC_TOP_9): digit = 4'd9;
`ifdef KEY_ENTRY_NUMPAD_EN
         SCAN_W'(SC_PAD_0): digit = 4'd0;
         SCAN_W'(SC_PAD_1): digit = 4'd1;
         SCAN_W'(SC_PAD_2): digit = 4'd2;
         SCAN_W'(SC_PAD_3): digit = 4'd3;
         SCAN_W'(SC_PAD_4): digit = 4'd4;
         SCAN_W'(SC_PAD_5): digit = 4'd5;
         SCAN_W'(SC_PAD_6): digit = 4'd6;
         SCAN_W'(SC_PAD_7): digit = 4'd7;
         SCAN_W'(SC_PAD_8): digit = 4'd8;
         SCAN_W'(SC_PAD_9): digit = 4'd9;
         SCAN_W'(SC_PAD_ENTER): key_class = KEY_ENTER;
`else
`endif
         SCAN_W'(SC_ENTER): key_class = KEY_ENTER;
         SCAN_W'(SC_BKSP):  key_class = KEY_BKSP;
         SCAN_W'(SC_ESC):   key_class = KEY_ESC;
         default:           key_class = KEY_NONE;
      endcase
   end

endmodule

// File: rtl/key_entry.sv
// Keyboard front-end: typematic filter, operand-entry FSM and BCD operand registers.
// Optional keypad support is selected with KEY_ENTRY_NUMPAD_EN (see scan_to_bcd).
module key_entry
   import key_entry_pkg::*;
#(
   parameter int SCAN_W = 9
) (
   input  logic        clk,
   input  logic        reset,
   key_entry_if.slave  ev,
   output logic [3:0]  operand_a,
   output logic [3:0]  operand_b,
   output logic [1:0]  entry_state,
   output logic        result_valid
);

   localparam logic [1:0] S_ENTER_A = ST_ENTER_A;
   localparam logic [1:0] S_ENTER_B = ST_ENTER_B;
   localparam logic [1:0] S_SHOW    = ST_SHOW;
   localparam logic [1:0] S_ILLEGAL = 2'd3;

   logic [SCAN_W-1:0] held_code;
   logic              held_valid;
   logic              accept;
   key_class_e        key_class;
   logic [3:0]        digit;
   logic [1:0]        state_n;
   logic [3:0]        a_n;
   logic [3:0]        b_n;

   scan_to_bcd #(.SCAN_W(SCAN_W)) u_scan_to_bcd (
      .code      (ev.last_change),
      .key_class (key_class),
      .digit     (digit)
   );

   // A make of the key already held down is typematic repeat and is dropped.
   assign accept = ev.key_valid && ev.key_make &&
                   (!held_valid || (ev.last_change != held_code));

   always_ff @(posedge clk) begin
      if (reset) begin
         held_code  <= '0;
         held_valid <= 1'b0;
      end else if (accept) begin
         held_code  <= ev.last_change;
         held_valid <= 1'b1;
      end else if (ev.key_valid && !ev.key_make && (ev.last_change == held_code)) begin
         held_valid <= 1'b0;
      end
   end

   always_comb begin
      state_n = entry_state;
      a_n     = operand_a;
      b_n     = operand_b;
      if (entry_state == S_ILLEGAL) begin
         state_n = S_ENTER_A;
         a_n     = 4'd0;
         b_n     = 4'd0;
      end else if (accept) begin
         case (key_class)
            KEY_DIGIT: begin
               case (entry_state)
                  S_ENTER_A: a_n = digit;
                  S_ENTER_B: b_n = digit;
                  default: begin
                     a_n     = digit;
                     b_n     = 4'd0;
                     state_n = S_ENTER_A;
                  end
               endcase
            end
            KEY_ENTER: begin
               if (entry_state == S_ENTER_A) state_n = S_ENTER_B;
               else                          state_n = S_SHOW;
            end
            KEY_BKSP: begin
               case (entry_state)
                  S_ENTER_A: a_n = 4'd0;
                  S_ENTER_B: begin
                     b_n     = 4'd0;
                     state_n = S_ENTER_A;
                  end
                  default: state_n = S_ENTER_B;
               endcase
            end
            KEY_ESC: begin
               a_n     = 4'd0;
               b_n     = 4'd0;
               state_n = S_ENTER_A;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         entry_state  <= S_ENTER_A;
         operand_a    <= 4'd0;
         operand_b    <= 4'd0;
         result_valid <= 1'b0;
      end else begin
         entry_state  <= state_n;
         operand_a    <= a_n;
         operand_b    <= b_n;
         result_valid <= (state_n == S_SHOW);
      end
   end

endmodule

// File: doc/key_entry.md
# key_entry

Keyboard front-end for the two-digit decimal adder display path. Consumes the PS/2 keyboard decoder's per-event outputs (`last_change`, `key_valid`, and the make/break bit `key_down[last_change]`) in the `clk` domain and turns key presses into two registered BCD operands for the decimal adder. A small entry state machine sequences the operands, and the block rejects typematic auto-repeat. It replaces the separate operand-select FSM and per-digit key latches.

## Interface
Parameters:
- `SCAN_W`, default 9: width of the extended scan code (`{E0 flag, 8-bit code}`).

Ports:
- `clk`  in  1: system clock. One clock for the whole block.
- `reset`  in  1: reset, synchronous and active-high.
- `key_valid`  in  1: one-cycle pulse from the keyboard decoder on each make or break event.
- `last_change`  in  `SCAN_W`: scan code of the event. Valid when `key_valid`=1.
- `key_make`  in  1: `key_down[last_change]`. 1 means make (press), 0 means break (release).
- `operand_a`  out  4: BCD digit for the adder's `num_0`.
- `operand_b`  out  4: BCD digit for the adder's `num_1`.
- `entry_state`  out  2: current state, for the display/LED.
- `result_valid`  out  1: high while both operands are committed (state SHOW).

## Operation
- Accepted press: `key_valid`=1, `key_make`=1, and `last_change` != `held_code`, or `held_valid`=0.
- On an accepted press: `held_code` ← `last_change` and `held_valid` ← 1.
- Break event whose code equals `held_code`: clears `held_valid`. All other breaks are ignored.
- Repeated makes of the held code are dropped (typematic repeat).
- Key classes. Any other code is ignored and leaves state unchanged.
  - Digit, top row: 0→0x45, 1→0x16, 2→0x1E, 3→0x26, 4→0x25, 5→0x2E, 6→0x36, 7→0x3D, 8→0x3E, 9→0x46.
  - ENTER: 0x05A.
  - BKSP: 0x066.
  - ESC: 0x076.
- States (2-bit encoding): ENTER_A=0, ENTER_B=1, SHOW=2. Code 3 is illegal and recovers to ENTER_A with both operands cleared.
- ENTER_A:
  - digit d → `operand_a`←d (overwrites any previous digit).
  - ENTER → ENTER_B.
  - BKSP → `operand_a`←0.
  - ESC → clear both operands.
- ENTER_B:
  - digit d → `operand_b`←d.
  - ENTER → SHOW.
  - BKSP → `operand_b`←0, go to ENTER_A.
  - ESC → clear both operands, go to ENTER_A.
- SHOW:
  - digit d → `operand_a`←d, `operand_b`←0, go to ENTER_A (new calculation).
  - ENTER → no change.
  - BKSP → ENTER_B, `operand_b` kept.
  - ESC → clear both operands, go to ENTER_A.
- `result_valid` = (state == SHOW), registered.
- Operands are always in the range 0–9. Non-BCD values never appear.

## Timing
- Reset values: `operand_a`=0, `operand_b`=0, `entry_state`=ENTER_A, `result_valid`=0, `held_valid`=0, `held_code`=0.
- Latency: all outputs update on the `clk` edge that samples `key_valid`=1. New values are visible the next cycle.
- At most one event per `key_valid` pulse. Back-to-back pulses on consecutive cycles are each processed in full.
- Inputs are sampled only when `key_valid`=1. `last_change` and `key_make` are don't-care otherwise.
- `reset` overrides any event in the same cycle. Reset mid-entry discards both operands and `held_code`.
- A press of a new key while another key is held is accepted. `held_code` moves to the new key.

## Configuration
- `KEY_ENTRY_NUMPAD_EN` defined: keypad codes are also digits, mapped to the same BCD values as the top row.
  - 0→0x070, 1→0x069, 2→0x072, 3→0x07A, 4→0x06B, 5→0x073, 6→0x074, 7→0x06C, 8→0x075, 9→0x07D.
  - Keypad Enter 0x15A is also treated as ENTER.
- `KEY_ENTRY_NUMPAD_EN` undefined: all of these codes are ignored keys and cause no state or operand change.
- The typematic rule (`held_code`) still applies to them in both builds.

## Structure
- Shared package `key_entry_pkg` holds:
  - the state enum (ENTER_A/ENTER_B/SHOW);
  - scan-code constants for the digits, ENTER, BKSP, ESC and the keypad codes;
  - the key-class enum (DIGIT/ENTER/BKSP/ESC/NONE).
- Sub-module `scan_to_bcd`: purely combinational; `last_change` → {class, 4-bit digit}. It contains the `KEY_ENTRY_NUMPAD_EN` guard.
- The top level holds the typematic filter, the FSM and the operand registers.

## Test plan
- Reset, then press 0x16 (make then break), ENTER, 0x3E, ENTER → `operand_a`=1, `operand_b`=8, `entry_state`=2, `result_valid`=1.
- Typematic: make 0x2E three times without a break, then ENTER → `operand_a`=5, state ENTER_B. Repeats cause no extra events.
- In ENTER_B with `operand_b`=7, press BKSP → `operand_b`=0, state ENTER_A, `operand_a` unchanged. Then ESC → both 0.
- In SHOW (3, 4), press 0x26 → `operand_a`=3, `operand_b`=0, state ENTER_A, `result_valid`=0 the next cycle.
- Keypad 0x069 then ENTER → with the macro: `operand_a`=1, state ENTER_B. Without the macro: `operand_a` unchanged; ENTER still advances to ENTER_B.
- Assert `reset` in the same cycle as a `key_valid` make of 0x46 in ENTER_B → all outputs at reset values, digit discarded.
